// File: rtl/brick_field.sv
`default_nettype none
// ============================================================================
//  Module      : brick_field
//  Description : ROWS x COLS brick array with HP_W-bit hit points per brick.
//                Loads per-level patterns, resolves ball hit requests over a
//                valid/ready handshake, keeps a saturating score and the
//                live-brick count, and exports a flat hp bus for rendering.
//  Revision    : 1.0 - initial release
// ============================================================================
module brick_field #(
  parameter int ROWS     = 4,
  parameter int COLS     = 16,
  parameter int HP_W     = 2,
  parameter int SCORE_W  = 14,
  parameter int PTS_HIT  = 1,
  parameter int PTS_KILL = 4,
  parameter int ROW_W    = $clog2(ROWS),
  parameter int COL_W    = $clog2(COLS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load_req,
  input  logic [2:0]                           load_level,
  output logic                                 load_busy,
  input  logic                                 hit_valid,
  input  logic [ROW_W-1:0]                     hit_row,
  input  logic [COL_W-1:0]                     hit_col,
  output logic                                 hit_ready,
  output logic                                 resp_valid,
  output logic                                 resp_brick,
  output logic                                 resp_kill,
  output logic [ROWS*COLS*HP_W-1:0]            bricks,
  output logic [$clog2(ROWS*COLS+1)-1:0]       remaining,
  output logic                                 cleared,
  output logic [SCORE_W-1:0]                   score
);

  localparam int N      = ROWS * COLS;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int HP_MAX = (1 << HP_W) - 1;
  localparam logic [SCORE_W:0]  SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   k_q, k_d;           // brick index being written during LOAD
  logic [HP_W-1:0]    phase_q, phase_d;   // (row + level) mod HP_MAX for the row being loaded
  logic [HP_W-1:0]    hp_q [N];
  logic [HP_W-1:0]    hp_d [N];
  logic [SCORE_W-1:0] score_q, score_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               loaded_q, loaded_d;
  logic [IDX_W-1:0]   idx_q, idx_d;       // flat index of the accepted hit
  logic               resp_valid_q, resp_valid_d;
  logic               resp_brick_q, resp_brick_d;
  logic               resp_kill_q, resp_kill_d;

  // Hit target lookup; out-of-range coordinates never address the array.
  logic               hit_in_range;
  logic [IDX_W-1:0]   hit_idx;
  logic [HP_W-1:0]    hit_hp;
  logic               row_end;
  logic [HP_W-1:0]    start_phase;
  logic [SCORE_W:0]   score_sum;

  // Decode the hit request and load-sequencing helpers.
  always_comb begin
    hit_in_range = (32'(hit_row) < 32'(ROWS)) && (32'(hit_col) < 32'(COLS));
    hit_idx      = IDX_W'(32'(hit_row) * 32'(COLS) + 32'(hit_col));
    hit_hp       = hit_in_range ? hp_q[hit_idx] : '0;
    row_end      = (32'(k_q) % 32'(COLS)) == 32'(COLS - 1);
    start_phase  = HP_W'(32'(load_level) % 32'(HP_MAX));
    score_sum    = {1'b0, score_q}
                 + (SCORE_W + 1)'(resp_kill_q ? (PTS_HIT + PTS_KILL) : PTS_HIT);
  end

  // Next-state logic for the IDLE / LOAD / RESP controller and the brick store.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    phase_d      = phase_q;
    hp_d         = hp_q;
    score_d      = score_q;
    remaining_d  = remaining_q;
    loaded_d     = loaded_q;
    idx_d        = idx_q;
    resp_valid_d = 1'b0;
    resp_brick_d = 1'b0;
    resp_kill_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          // A load always wins over a hit offered in the same cycle.
          state_d     = ST_LOAD;
          k_d         = '0;
          phase_d     = start_phase;
          remaining_d = '0;
          if (load_level == 3'd0) begin
            score_d = '0;
          end
        end else if (hit_valid) begin
          // The array cannot change before RESP, so the response flags are
          // resolved here and presented as registered outputs next cycle.
          state_d      = ST_RESP;
          idx_d        = hit_idx;
          resp_valid_d = 1'b1;
          resp_brick_d = (hit_hp != '0);
          resp_kill_d  = (hit_hp == HP_W'(1));
        end
      end

      ST_LOAD: begin
        hp_d[k_q]   = phase_q + HP_W'(1);
        remaining_d = remaining_q + CNT_W'(1);
        if (k_q == LAST_IDX) begin
          state_d  = ST_IDLE;
          loaded_d = 1'b1;
        end else begin
          k_d = k_q + IDX_W'(1);
          if (row_end) begin
            phase_d = (32'(phase_q) == 32'(HP_MAX - 1)) ? '0 : phase_q + HP_W'(1);
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        if (resp_brick_q) begin
          hp_d[idx_q] = hp_q[idx_q] - HP_W'(1);
          score_d     = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0]
                                                : score_sum[SCORE_W-1:0];
          if (resp_kill_q) begin
            remaining_d = remaining_q - CNT_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any partial load or pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      phase_q      <= '0;
      for (int i = 0; i < N; i++) begin
        hp_q[i] <= '0;
      end
      score_q      <= '0;
      remaining_q  <= '0;
      loaded_q     <= 1'b0;
      idx_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_brick_q <= 1'b0;
      resp_kill_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      phase_q      <= phase_d;
      hp_q         <= hp_d;
      score_q      <= score_d;
      remaining_q  <= remaining_d;
      loaded_q     <= loaded_d;
      idx_q        <= idx_d;
      resp_valid_q <= resp_valid_d;
      resp_brick_q <= resp_brick_d;
      resp_kill_q  <= resp_kill_d;
    end
  end

  // Flatten the hp store onto the render bus, brick (row*COLS+col) at slot k.
  generate
    for (genvar g = 0; g < N; g++) begin : g_bricks
      assign bricks[g*HP_W +: HP_W] = hp_q[g];
    end
  endgenerate

  assign load_busy  = (state_q == ST_LOAD);
  assign hit_ready  = (state_q == ST_IDLE) && !load_req;
  assign resp_valid = resp_valid_q;
  assign resp_brick = resp_brick_q;
  assign resp_kill  = resp_kill_q;
  assign remaining  = remaining_q;
  assign score      = score_q;
  assign cleared    = loaded_q && (remaining_q == '0) && !load_busy;

endmodule
`default_nettype wire

// File: tb/tb_brick_field.sv
`default_nettype none
// ============================================================================
//  Module      : tb_brick_field
//  Description : Self-checking bench for brick_field against a behavioural
//                model of the brick field (hp array, score, remaining count).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_brick_field;

  localparam int ROWS = 4;
  localparam int COLS = 16;
  localparam int HP_W = 2;
  localparam int SCORE_W = 14;
  localparam int N = ROWS * COLS;
  localparam int SMAX = 16383;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_req = 1'b0;
  logic [2:0]   load_level = 3'd0;
  logic         load_busy;
  logic         hit_valid = 1'b0;
  logic [1:0]   hit_row = 2'd0;
  logic [4:0]   hit_col = 5'd0;
  logic         hit_ready;
  logic         resp_valid;
  logic         resp_brick;
  logic         resp_kill;
  logic [127:0] bricks;
  logic [6:0]   remaining;
  logic         cleared;
  logic [13:0]  score;

  always #5 clk = ~clk;

  brick_field #(
    .ROWS(ROWS), .COLS(COLS), .HP_W(HP_W), .SCORE_W(SCORE_W),
    .PTS_HIT(1), .PTS_KILL(4), .ROW_W(2), .COL_W(5)
  ) dut (
    .clk(clk), .rst(rst),
    .load_req(load_req), .load_level(load_level), .load_busy(load_busy),
    .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col), .hit_ready(hit_ready),
    .resp_valid(resp_valid), .resp_brick(resp_brick), .resp_kill(resp_kill),
    .bricks(bricks), .remaining(remaining), .cleared(cleared), .score(score)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model of the field
  int hp_m [N];
  int score_m = 0;
  int rem_m = 0;
  bit loaded_m = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_bricks();
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*HP_W +: HP_W] = 2'(hp_m[k]);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) hp_m[k] = 0;
    score_m = 0;
    rem_m = 0;
    loaded_m = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_bricks"}, bricks, model_bricks());
    check({tag, "_remaining"}, 128'(remaining), 128'(rem_m));
    check({tag, "_score"}, 128'(score), 128'(score_m));
    check({tag, "_cleared"}, 128'(cleared), 128'(loaded_m && rem_m == 0));
  endtask

  // Called at a negedge; returns at a negedge after the load finishes.
  task automatic do_load(input int lvl, input bit with_hit);
    int cnt;
    bit saw_bad;
    load_req = 1'b1;
    load_level = 3'(lvl);
    if (with_hit) begin
      hit_valid = 1'b1;
      hit_row = 2'd1;
      hit_col = 5'd3;
    end
    @(negedge clk);
    load_req = 1'b0;
    cnt = 0;
    saw_bad = 1'b0;
    while (load_busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (hit_ready !== 1'b0 || resp_valid !== 1'b0) saw_bad = 1'b1;
      @(negedge clk);
    end
    hit_valid = 1'b0;
    check("load_cycles", 128'(cnt), 128'(N));
    check("load_blocks_hits", 128'(saw_bad), 128'(0));
    for (int k = 0; k < N; k++) hp_m[k] = 1 + ((k / COLS + lvl) % 3);
    rem_m = N;
    if (lvl == 0) score_m = 0;
    loaded_m = 1'b1;
    check_state("after_load");
  endtask

  // Called at a negedge; one request, response checked one cycle later.
  task automatic do_hit(input int r, input int c);
    bit in_rng, live, kill;
    int idx, pts;
    in_rng = (r < ROWS) && (c < COLS);
    idx = r * COLS + c;
    live = in_rng && (hp_m[idx] != 0);
    kill = live && (hp_m[idx] == 1);
    check("hit_ready_idle", 128'(hit_ready), 128'(1));
    hit_valid = 1'b1;
    hit_row = 2'(r);
    hit_col = 5'(c);
    @(negedge clk);
    hit_valid = 1'b0;
    check("resp_valid", 128'(resp_valid), 128'(1));
    check("resp_brick", 128'(resp_brick), 128'(live));
    check("resp_kill", 128'(resp_kill), 128'(kill));
    check("hit_ready_resp", 128'(hit_ready), 128'(0));
    if (live) begin
      hp_m[idx]--;
      pts = kill ? 5 : 1;
      score_m = (score_m + pts > SMAX) ? SMAX : score_m + pts;
      if (kill) rem_m--;
    end
    @(negedge clk);
    check("resp_pulse_end", 128'(resp_valid), 128'(0));
    check_state("after_hit");
  endtask

  task automatic clear_all();
    for (int k = 0; k < N; k++) begin
      while (hp_m[k] > 0) do_hit(k / COLS, k % COLS);
    end
  endtask

  initial begin
    int iter;
    model_reset();
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 128'(load_busy), 128'(0));
    check("rst_resp", 128'(resp_valid), 128'(0));
    check("rst_ready", 128'(hit_ready), 128'(1));
    check_state("rst");

    // Level 0 pattern and directed hits
    do_load(0, 1'b0);
    check("lvl0_row2_hp", 128'(bricks[(2*COLS)*HP_W +: HP_W]), 128'(3));
    do_hit(0, 5);
    check("kill_score", 128'(score), 128'(5));
    check("kill_remaining", 128'(remaining), 128'(63));
    do_hit(2, 0);
    check("r2c0_score1", 128'(score), 128'(6));
    do_hit(2, 0);
    check("r2c0_score2", 128'(score), 128'(7));
    do_hit(2, 0);
    check("r2c0_score3", 128'(score), 128'(12));
    do_hit(1, 16);   // column out of range
    do_hit(0, 5);    // dead brick
    check("dead_score", 128'(score), 128'(12));

    // Load and hit offered together: load wins, score kept (level != 0)
    do_load(2, 1'b1);
    check("load_keeps_score", 128'(score), 128'(12));

    // Randomized hits including out-of-range columns
    for (int i = 0; i < 120; i++) do_hit($urandom_range(0, 3), $urandom_range(0, 16));

    // Reset in the middle of a load
    load_req = 1'b1;
    load_level = 3'd1;
    @(negedge clk);
    load_req = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("midload_rst_busy", 128'(load_busy), 128'(0));
    check_state("midload_rst");

    // Destroy every brick
    do_load(0, 1'b0);
    clear_all();
    check("all_cleared", 128'(cleared), 128'(1));
    check("all_remaining", 128'(remaining), 128'(0));

    // Keep playing levels until the score saturates
    iter = 0;
    while (score_m < SMAX && iter < 60) begin
      do_load(1 + (iter % 7), 1'b0);
      clear_all();
      iter++;
    end
    check("score_saturated", 128'(score), 128'(SMAX));
    do_load(3, 1'b0);
    do_hit(0, 0);
    check("score_stays_max", 128'(score), 128'(SMAX));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
